alu_result_sink: RTL
====================

ALU_RESULT_SINK -- requirements
Module: alu_result_sink

Interface
REQ-001 Parameter: DEPTH, 4, result-queue entries; SHALL be a power of two, >=2.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; SHALL clear all state immediately, independent of clock.
REQ-004 in_valid  input  1  producer offers a packed ALU result word.
REQ-005 in_ready  output  1  sink can accept; transfer SHALL occur on a clock edge where in_valid && in_ready.
REQ-006 in_word  input  20  packed result: [15:0] data, [16] S, [17] V, [18] Z, [19] C.
REQ-007 in_setf  input  1  when 1, the accepted word SHALL update the flag register.
REQ-008 out_valid  output  1  queue head holds data.
REQ-009 out_ready  input  1  consumer takes head; pop SHALL occur on an edge where out_valid && out_ready.
REQ-010 out_data  output  16  data field of queue head; 16'h0000 when empty.
REQ-011 flag_s, flag_v, flag_z, flag_c  output  1 each  current flag register.
REQ-012 cond_req  input  1  request a branch-condition evaluation.
REQ-013 cond_sel  input  3  0 BE(Z), 1 BLT(S^V), 2 BLE(Z|(S^V)), 3 BNE(!Z), 4 always, 5-7 never.
REQ-014 cond_valid  output  1  registered; high exactly one cycle after each cond_req.
REQ-015 cond_taken  output  1  registered evaluation result, qualified by cond_valid; 0 otherwise.

Function
REQ-016 Result queue SHALL be a FIFO of DEPTH 16-bit entries with write pointer, read pointer and count of width log2(DEPTH)+1; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 in_ready SHALL equal (count < DEPTH), combinationally from registered state only (no path from out_ready).
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer, first-word latency one cycle after acceptance.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-020 Full (count == DEPTH): in_ready=0; a concurrent pop SHALL free one entry, visible as in_ready=1 the next cycle.
REQ-021 Empty: pop SHALL not occur; a push SHALL make out_valid=1 the next cycle.
REQ-022 Flag register SHALL load {S,V,Z,C} from in_word[16..19] on the accept edge when in_setf=1, otherwise hold; loading SHALL be independent of queue occupancy at pop time.
REQ-023 Condition evaluation SHALL use the flag register value before the edge; a flag load in the same cycle as cond_req SHALL NOT affect that evaluation.
REQ-024 State machine: IDLE (cond_valid=0) -> EVAL on cond_req; EVAL (cond_valid=1) -> EVAL if cond_req, else IDLE; back-to-back requests SHALL produce back-to-back results.
REQ-025 in_word bits are taken verbatim; no recomputation of flags from data SHALL occur.

Reset
REQ-026 On reset assertion: count=0, pointers=0, in_ready=1, out_valid=0, out_data=16'h0000, all flags=0, state IDLE, cond_valid=0, cond_taken=0.
REQ-027 Reset mid-operation SHALL discard queued entries and any pending evaluation; no output SHALL reflect pre-reset contents after release.
REQ-028 After deassertion, the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-029 Push 20'h4_0000 (Z=1, data 0) with in_setf=1, then cond_req sel=0 -> flag_z=1, cond_valid=1 next cycle, cond_taken=1; out_data=16'h0000, out_valid=1.
REQ-030 DEPTH=4, out_ready=0, push 16'h0001..16'h0005 continuously -> four accepted, in_ready=0 after 4th; then drain -> out_data 1,2,3,4 in order, 5th accepted once space frees.
REQ-031 Push word with S=1,V=0 setf=1, cond_req sel=1 and sel=2 on consecutive cycles -> cond_taken=1,1; sel=3 -> 1; sel=5 -> 0.
REQ-032 Same cycle: accept word Z=1 setf=1 and cond_req sel=0 with flags previously 0 -> cond_taken=0; next cond_req sel=0 -> 1.
REQ-033 Push 16'hBEEF with setf=0 after flags loaded C=1 -> flags unchanged, out_data=16'hBEEF.
REQ-034 Queue holding 3 entries, flags nonzero, assert reset asynchronously between edges -> out_valid=0, in_ready=1, flags=0, cond_valid=0 before the next edge.

Source files
------------

// File: rtl/alu_result_sink.sv
// -----------------------------------------------------------------------------
// alu_result_sink
//
// Receives packed ALU result words and does two things with each one. The
// 16-bit data field goes into a small FIFO, which a downstream consumer drains.
// When in_setf is set, the four status flags in the word load a flag register.
// That flag register feeds a one-cycle branch-condition evaluator.
//
// Ports
//   clock        : sole clock; all state updates on its rising edge
//   reset        : asynchronous, active-high; clears queue, flags and evaluator
//   in_valid     : producer offers in_word
//   in_ready     : queue has a free entry (depends on registered state only)
//   in_word[19:0]: [15:0] data, [16] S, [17] V, [18] Z, [19] C
//   in_setf      : accepted word also loads the flag register
//   out_valid    : queue head holds data
//   out_ready    : consumer takes the head this edge
//   out_data     : data at queue head, 16'h0000 when empty
//   flag_s/v/z/c : current flag register
//   cond_req     : request a branch-condition evaluation
//   cond_sel[2:0]: 0 BE, 1 BLT, 2 BLE, 3 BNE, 4 always, 5-7 never
//   cond_valid   : high exactly one cycle after each cond_req
//   cond_taken   : evaluation result, 0 whenever cond_valid is 0
//
// Parameter
//   DEPTH        : number of queue entries; must be a power of two, >= 2
// -----------------------------------------------------------------------------
module alu_result_sink #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_word,
  input  logic        in_setf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        flag_s,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_c,
  input  logic        cond_req,
  input  logic [2:0]  cond_sel,
  output logic        cond_valid,
  output logic        cond_taken
);

  // Pointers are log2(DEPTH) bits wide. Because DEPTH is a power of two, they
  // wrap from DEPTH-1 to 0 naturally. The count needs one more bit so that it
  // can represent the full state (count == DEPTH).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PONE_C  = AW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          s_reg, s_next;
  logic          v_reg, v_next;
  logic          z_reg, z_next;
  logic          c_reg, c_next;
  state_t        state_reg, state_next;
  logic          taken_reg, taken_next;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic push;
  logic pop;

  // in_ready is derived from count_reg alone. This keeps out_ready off the
  // input handshake path. As a result, a slot freed by a pop while the queue
  // is full only becomes visible on the following cycle.
  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The data output is gated by occupancy. Stale array contents, including
  // those left over from before a reset, never reach the port.
  assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : 16'h0000;

  assign flag_s = s_reg;
  assign flag_v = v_reg;
  assign flag_z = z_reg;
  assign flag_c = c_reg;

  // ---------------------------------------------------------------------------
  // Queue next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PONE_C;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PONE_C;
    end

    // When a push and a pop happen together, the count does not change.
    unique case ({push, pop})
      2'b10:   count_next = count_reg + ONE_C;
      2'b01:   count_next = count_reg - ONE_C;
      default: count_next = count_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Flag register next-state
  // ---------------------------------------------------------------------------
  // The flags come straight from the word. Nothing is recomputed from the data
  // field. Loading happens on the accept edge, independent of when the entry
  // is later popped.
  always_comb begin
    s_next = s_reg;
    v_next = v_reg;
    z_next = z_reg;
    c_next = c_reg;
    if (push && in_setf) begin
      s_next = in_word[16];
      v_next = in_word[17];
      z_next = in_word[18];
      c_next = in_word[19];
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluator: next-state and registered outputs
  // ---------------------------------------------------------------------------
  // The evaluation reads the flag registers, not their next values. A flag
  // load in the same cycle as cond_req therefore does not affect the result.
  always_comb begin
    logic lt;
    lt         = s_reg ^ v_reg;
    state_next = cond_req ? EVAL : IDLE;
    taken_next = 1'b0;
    if (cond_req) begin
      unique case (cond_sel)
        3'd0:    taken_next = z_reg;
        3'd1:    taken_next = lt;
        3'd2:    taken_next = z_reg | lt;
        3'd3:    taken_next = ~z_reg;
        3'd4:    taken_next = 1'b1;
        default: taken_next = 1'b0;
      endcase
    end
  end

  assign cond_valid = (state_reg == EVAL);
  assign cond_taken = taken_reg;

  // ---------------------------------------------------------------------------
  // State registers (asynchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      s_reg      <= 1'b0;
      v_reg      <= 1'b0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      state_reg  <= IDLE;
      taken_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      s_reg      <= s_next;
      v_reg      <= v_next;
      z_reg      <= z_next;
      c_reg      <= c_next;
      state_reg  <= state_next;
      taken_reg  <= taken_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // The storage array has no reset, so it can map onto RAM. Its contents are
  // don't-care whenever the count says the slot is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_word[15:0];
    end
  end

endmodule
